// File: rtl/video_pixel_tracker_if.sv
// Stream bundle for video_pixel_tracker: Avalon-ST video sink side plus the
// registered per-pixel output side consumed by the filter stages.
// slave  : the tracker (consumes sink_*, produces out_*)
// master : the environment (produces sink_*, consumes out_*)
interface video_pixel_tracker_if;
   logic [23:0] sink_data;
   logic        sink_valid;
   logic        sink_sop;
   logic        sink_eop;
   logic        sink_ready;

   logic        out_valid;
   logic        out_ready;
   logic        out_sop;
   logic        out_eop;
   logic [7:0]  out_r;
   logic [7:0]  out_g;
   logic [7:0]  out_b;
   logic [10:0] out_x;
   logic [10:0] out_y;
   logic        out_packet_video;

   modport slave (
      input  sink_data, sink_valid, sink_sop, sink_eop, out_ready,
      output sink_ready, out_valid, out_sop, out_eop, out_r, out_g, out_b,
             out_x, out_y, out_packet_video
   );

   modport master (
      output sink_data, sink_valid, sink_sop, sink_eop, out_ready,
      input  sink_ready, out_valid, out_sop, out_eop, out_r, out_g, out_b,
             out_x, out_y, out_packet_video
   );
endinterface

// File: rtl/video_pixel_tracker.sv
// video_pixel_tracker: parses Avalon-ST video packets, tags each forwarded
// beat with packet-video flag and (x, y), counts frames, flags malformed ones.
// One registered output stage with backpressure; every beat passes through.
// Optional feature: define CTRL_PARSE_EN to decode width/height from CTRL
// packets (type 0xF); otherwise active W/H are fixed at IMAGE_W/IMAGE_H.
//
// state | meaning
// IDLE  | between packets, waiting for SOP
// VIDEO | inside a type-0 packet, pixels carry coordinates
// CTRL  | inside a type-0xF control packet
// SKIP  | inside any other packet type, forwarded untouched
module video_pixel_tracker #(
   parameter int IMAGE_W = 640,
   parameter int IMAGE_H = 480,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   video_pixel_tracker_if.slave bus,
   output logic [CNT_W-1:0]     frame_count,
   output logic                 frame_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] VIDEO = 2'd1;
   localparam logic [1:0] CTRL  = 2'd2;
   localparam logic [1:0] SKIP  = 2'd3;

   localparam logic [10:0] IMG_W = 11'(IMAGE_W);
   localparam logic [10:0] IMG_H = 11'(IMAGE_H);

   logic [1:0]  state, nxt_state;
   logic [10:0] x, y, nxt_x, nxt_y;
   logic        done, nxt_done;
   logic [10:0] o_x, o_y;
   logic        o_pv;
   logic        set_err, inc_frame;
   logic [10:0] act_w, act_h;
   logic [10:0] w_m1, h_m1;
   logic [3:0]  sop_type;
   logic        accept;

   assign bus.sink_ready = ~bus.out_valid | bus.out_ready;
   assign accept         = bus.sink_valid & bus.sink_ready;
   assign sop_type       = bus.sink_data[3:0];
   assign w_m1           = act_w - 11'd1;
   assign h_m1           = act_h - 11'd1;

`ifdef CTRL_PARSE_EN
   logic [1:0]  ctrl_beat;
   logic [15:0] ctrl_w;
   logic [7:0]  ctrl_h_hi;
   logic [15:0] full_h;
   logic [10:0] stg_w, stg_h;

   assign full_h = {ctrl_h_hi, bus.sink_data[19:16], bus.sink_data[11:8]};

   // Collect CTRL nibbles, stage legal sizes, apply them at the next VIDEO SOP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_beat <= 2'd0;
         ctrl_w    <= 16'd0;
         ctrl_h_hi <= 8'd0;
         stg_w     <= IMG_W;
         stg_h     <= IMG_H;
         act_w     <= IMG_W;
         act_h     <= IMG_H;
      end else if (accept) begin
         if (bus.sink_sop) begin
            ctrl_beat <= 2'd0;
            if (sop_type == 4'h0) begin
               act_w <= stg_w;
               act_h <= stg_h;
            end
         end else if (state == CTRL) begin
            case (ctrl_beat)
               2'd0: begin
                  ctrl_w[15:4] <= {bus.sink_data[19:16], bus.sink_data[11:8],
                                   bus.sink_data[3:0]};
                  ctrl_beat    <= 2'd1;
               end
               2'd1: begin
                  ctrl_w[3:0] <= bus.sink_data[19:16];
                  ctrl_h_hi   <= {bus.sink_data[11:8], bus.sink_data[3:0]};
                  ctrl_beat   <= 2'd2;
               end
               2'd2: begin
                  if (ctrl_w != 16'd0 && ctrl_w <= 16'd2047) stg_w <= ctrl_w[10:0];
                  if (full_h != 16'd0 && full_h <= 16'd2047) stg_h <= full_h[10:0];
                  ctrl_beat <= 2'd3;
               end
               default: ctrl_beat <= 2'd3;
            endcase
         end
      end
   end
`else
   assign act_w = IMG_W;
   assign act_h = IMG_H;
`endif

   // Next-state, coordinate and status decisions for the beat being accepted.
   always_comb begin
      nxt_state = state;
      nxt_x     = x;
      nxt_y     = y;
      nxt_done  = done;
      o_x       = 11'd0;
      o_y       = 11'd0;
      o_pv      = 1'b0;
      set_err   = 1'b0;
      inc_frame = 1'b0;
      if (bus.sink_sop) begin
         // A SOP always restarts parsing; one inside a packet means truncation.
         if (state != IDLE) set_err = 1'b1;
         nxt_x    = 11'd0;
         nxt_y    = 11'd0;
         nxt_done = 1'b0;
         o_pv     = (sop_type == 4'h0);
         if (bus.sink_eop) begin
            nxt_state = IDLE;
            if (sop_type == 4'h0) begin
               inc_frame = 1'b1;
               set_err   = 1'b1;
            end
         end else if (sop_type == 4'h0) begin
            nxt_state = VIDEO;
         end else if (sop_type == 4'hF) begin
            nxt_state = CTRL;
         end else begin
            nxt_state = SKIP;
         end
      end else begin
         case (state)
            VIDEO: begin
               o_pv = 1'b1;
               if (done) begin
                  // Pixels beyond the frame stick at the last coordinate.
                  o_x     = w_m1;
                  o_y     = h_m1;
                  set_err = 1'b1;
               end else begin
                  o_x = x;
                  o_y = y;
                  if (x == w_m1) begin
                     if (y == h_m1) begin
                        nxt_done = 1'b1;
                     end else begin
                        nxt_x = 11'd0;
                        nxt_y = y + 11'd1;
                     end
                  end else begin
                     nxt_x = x + 11'd1;
                  end
               end
               if (bus.sink_eop) begin
                  inc_frame = 1'b1;
                  nxt_state = IDLE;
                  if (!(done || (x == w_m1 && y == h_m1))) set_err = 1'b1;
                  nxt_x    = 11'd0;
                  nxt_y    = 11'd0;
                  nxt_done = 1'b0;
               end
            end
            CTRL, SKIP: begin
               if (bus.sink_eop) nxt_state = IDLE;
            end
            default: ;
         endcase
      end
   end

   // Parser state, frame counter and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         x           <= 11'd0;
         y           <= 11'd0;
         done        <= 1'b0;
         frame_count <= '0;
         frame_err   <= 1'b0;
      end else if (accept) begin
         state <= nxt_state;
         x     <= nxt_x;
         y     <= nxt_y;
         done  <= nxt_done;
         if (inc_frame) frame_count <= frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
         if (set_err)   frame_err   <= 1'b1;
      end
   end

   // Output register: load on accept, hold while stalled, drop valid when drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid        <= 1'b0;
         bus.out_sop          <= 1'b0;
         bus.out_eop          <= 1'b0;
         bus.out_r            <= 8'd0;
         bus.out_g            <= 8'd0;
         bus.out_b            <= 8'd0;
         bus.out_x            <= 11'd0;
         bus.out_y            <= 11'd0;
         bus.out_packet_video <= 1'b0;
      end else if (accept) begin
         bus.out_valid        <= 1'b1;
         bus.out_sop          <= bus.sink_sop;
         bus.out_eop          <= bus.sink_eop;
         bus.out_r            <= bus.sink_data[23:16];
         bus.out_g            <= bus.sink_data[15:8];
         bus.out_b            <= bus.sink_data[7:0];
         bus.out_x            <= o_x;
         bus.out_y            <= o_y;
         bus.out_packet_video <= o_pv;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_video_pixel_tracker.sv
// Scoreboard bench for video_pixel_tracker using a reduced 20x6 image so
// full frames stay short. Driver pushes expected beats; monitor pops and
// compares whenever an output beat is consumed, and checks stall stability.
module tb_video_pixel_tracker;
   localparam int W0 = 20;
   localparam int H0 = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] frame_count;
   logic        frame_err;
   bit          bp_mode = 1'b0;

   always #5 clk = ~clk;

   video_pixel_tracker_if bus();

   video_pixel_tracker #(.IMAGE_W(W0), .IMAGE_H(H0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .frame_count(frame_count), .frame_err(frame_err)
   );

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [23:0] data;
      logic [10:0] x;
      logic [10:0] y;
      logic        pv;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t snap;
   bit    stalled = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic beat_t cur_beat();
      beat_t b;
      b.sop  = bus.out_sop;
      b.eop  = bus.out_eop;
      b.data = {bus.out_r, bus.out_g, bus.out_b};
      b.x    = bus.out_x;
      b.y    = bus.out_y;
      b.pv   = bus.out_packet_video;
      return b;
   endfunction

   // Monitor: stall stability and scoreboard comparison on consumed beats.
   always @(negedge clk) begin
      beat_t c, e;
      if (!rst) begin
         c = cur_beat();
         if (stalled) check("stall_hold", 64'({bus.out_valid, c}), 64'({1'b1, snap}));
         if (bus.out_valid && !bus.out_ready) begin
            stalled = 1'b1;
            snap    = c;
         end else begin
            stalled = 1'b0;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got %0h required none", c);
            end else begin
               e = exp_q.pop_front();
               check("beat_xy",    64'({c.x, c.y}), 64'({e.x, e.y}));
               check("beat_data",  64'(c.data), 64'(e.data));
               check("beat_flags", 64'({c.sop, c.eop, c.pv}), 64'({e.sop, e.eop, e.pv}));
            end
         end
      end else begin
         stalled = 1'b0;
      end
   end

   // Backpressure generator: toggles out_ready every cycle when enabled.
   always @(posedge clk) begin
      if (bp_mode) begin
         #1;
         bus.out_ready = ~bus.out_ready;
      end
   end

   task automatic send(input logic [23:0] d, input logic s, input logic e,
                       input int ex, input int ey, input logic epv);
      bit    acc;
      beat_t b;
      bus.sink_data  = d;
      bus.sink_sop   = s;
      bus.sink_eop   = e;
      bus.sink_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 1000 && !acc; t++) begin
         @(negedge clk);
         acc = bus.sink_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no sink_ready required ready within 1000 cycles");
      end else begin
         b.sop  = s;
         b.eop  = e;
         b.data = d;
         b.x    = 11'(ex);
         b.y    = 11'(ey);
         b.pv   = epv;
         exp_q.push_back(b);
      end
   endtask

   task automatic idle();
      bus.sink_valid = 1'b0;
      bus.sink_sop   = 1'b0;
      bus.sink_eop   = 1'b0;
   endtask

   // Type-0 packet: header then n pixels, coordinates row-major, saturating.
   task automatic send_video(input int n, input int w, input int h, input bit term);
      int ex, ey;
      send(24'h000000, 1'b1, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < n; i++) begin
         if (i < w * h) begin
            ex = i % w;
            ey = i / w;
         end else begin
            ex = w - 1;
            ey = h - 1;
         end
         send(24'((i * 37 + 11) ^ 24'h5A5A00), 1'b0, term && (i == n - 1), ex, ey, 1'b1);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && t < 2000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 2000) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d beats pending required 0", exp_q.size());
      end
   endtask

   initial begin
      int cw, ch;
      rst = 1'b1;
      bus.out_ready = 1'b1;
      idle();
      bus.sink_data = 24'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid",   64'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_packet_video}), 64'd0);
      check("rst_data",    64'({bus.out_r, bus.out_g, bus.out_b}), 64'd0);
      check("rst_xy",      64'({bus.out_x, bus.out_y}), 64'd0);
      check("rst_status",  64'({frame_count, frame_err}), 64'd0);
      check("rst_ready",   64'(bus.sink_ready), 64'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Full frame, no backpressure.
      send_video(W0 * H0, W0, H0, 1'b1);
      idle();
      drain();
      check("f1_count", 64'(frame_count), 64'd1);
      check("f1_err",   64'(frame_err), 64'd0);

      // Full frame with out_ready toggling every cycle.
      bp_mode = 1'b1;
      send_video(W0 * H0, W0, H0, 1'b1);
      idle();
      drain();
      bp_mode = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      check("f2_count", 64'(frame_count), 64'd2);
      check("f2_err",   64'(frame_err), 64'd0);

      // Stray beat in IDLE, then a 10-beat type-3 packet.
      send(24'hABCDE0, 1'b0, 1'b0, 0, 0, 1'b0);
      send(24'h123453, 1'b1, 1'b0, 0, 0, 1'b0);
      for (int i = 1; i < 10; i++)
         send(24'(i * 24'h010203), 1'b0, i == 9, 0, 0, 1'b0);
      idle();
      drain();
      check("skip_count", 64'(frame_count), 64'd2);
      check("skip_err",   64'(frame_err), 64'd0);

      // CTRL packet encoding 10x4, then a 40-pixel frame.
`ifdef CTRL_PARSE_EN
      cw = 10;
      ch = 4;
`else
      cw = W0;
      ch = H0;
`endif
      send(24'h00000F, 1'b1, 1'b0, 0, 0, 1'b0);
      send(24'h000000, 1'b0, 1'b0, 0, 0, 1'b0);
      send(24'h0A0000, 1'b0, 1'b0, 0, 0, 1'b0);
      send(24'h000400, 1'b0, 1'b1, 0, 0, 1'b0);
      send_video(40, cw, ch, 1'b1);
      idle();
      drain();
      check("ctrl_count", 64'(frame_count), 64'd3);
`ifdef CTRL_PARSE_EN
      check("ctrl_err", 64'(frame_err), 64'd0);
`else
      check("ctrl_err", 64'(frame_err), 64'd1);
`endif

      // Short frame: half the pixels.
      send_video((cw * ch) / 2, cw, ch, 1'b1);
      idle();
      drain();
      check("short_count", 64'(frame_count), 64'd4);
      check("short_err",   64'(frame_err), 64'd1);

      // New frame restarts at (0,0); reset lands mid-frame.
      send_video(15, cw, ch, 1'b0);
      rst = 1'b1;
      #1;
      check("mrst_valid",  64'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_packet_video}), 64'd0);
      check("mrst_xy",     64'({bus.out_x, bus.out_y, bus.out_r}), 64'd0);
      check("mrst_status", 64'({frame_count, frame_err}), 64'd0);
      exp_q.delete();
      idle();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // After reset, default size applies again and the count restarts.
      send_video(W0 * H0, W0, H0, 1'b1);
      idle();
      drain();
      check("post_count", 64'(frame_count), 64'd1);
      check("post_err",   64'(frame_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish required finish by 500000");
      $fatal(1, "timeout");
   end

endmodule
